// File: rtl/sbtx_link_ctrl.sv
// Sideband transmit-side connection controller.
// Holds SBTX low for the disconnect minimum, then drives it high and
// qualifies the partner's SBRX response. Reports connect, partner
// disconnect and connect timeout to the logical-layer FSM.
module sbtx_link_ctrl #(
  parameter int unsigned TDISCONNECT_TX   = 50,
  parameter int unsigned TCONNECT_RX      = 25,
  parameter int unsigned TDISCONNECT_RX   = 14,
  parameter int unsigned TCONNECT_TIMEOUT = 1000
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       connect_en,
  input  logic       disconnect_req,
  input  logic       disable_req,
  input  logic       sbrx,
  output logic       sbtx,
  output logic       link_connected,
  output logic       tdisconnect_tx_done,
  output logic       connect_timeout,
  output logic       partner_disconnect,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_DISC      = 2'd0,
    ST_CONN_TX   = 2'd1,
    ST_CONNECTED = 2'd2,
    ST_DISABLED  = 2'd3
  } state_e;

  // Counter limits, pre-computed as 16-bit values. The "_LAST" constants
  // are the count already held when the qualifying sample arrives.
  localparam logic [15:0] TX_MAX   = 16'(TDISCONNECT_TX);
  localparam logic [15:0] CRX_LAST = 16'(TCONNECT_RX - 1);
  localparam logic [15:0] DRX_LAST = 16'(TDISCONNECT_RX - 1);
  localparam logic [15:0] TO_LAST  = 16'(TCONNECT_TIMEOUT - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  state_e      state_q, state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        connect_timeout_q, connect_timeout_d;
  logic        partner_disconnect_q, partner_disconnect_d;

  // Saturating increment: never wraps past lim.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] lim);
    logic [15:0] r;
    if (v >= lim) begin
      r = lim;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  // Next-state and counter logic: state rules first, then request overrides.
  always_comb begin
    state_d              = state_q;
    tx_cnt_d             = tx_cnt_q;
    rx_cnt_d             = rx_cnt_q;
    to_cnt_d             = to_cnt_q;
    connect_timeout_d    = 1'b0;
    partner_disconnect_d = 1'b0;

    case (state_q)
      ST_DISC: begin
        tx_cnt_d = sat_inc(tx_cnt_q, TX_MAX);
        if ((tx_cnt_q == TX_MAX) && connect_en) begin
          state_d = ST_CONN_TX;
        end else begin
          state_d = ST_DISC;
        end
      end
      ST_CONN_TX: begin
        to_cnt_d = sat_inc(to_cnt_q, CNT_MAX);
        if (sbrx) begin
          rx_cnt_d = sat_inc(rx_cnt_q, CNT_MAX);
        end else begin
          rx_cnt_d = 16'd0;
        end
        // Qualification beats a coincident timeout.
        if (sbrx && (rx_cnt_q == CRX_LAST)) begin
          state_d = ST_CONNECTED;
        end else if (to_cnt_q == TO_LAST) begin
          state_d           = ST_DISC;
          connect_timeout_d = 1'b1;
        end else begin
          state_d = ST_CONN_TX;
        end
      end
      ST_CONNECTED: begin
        if (!sbrx) begin
          rx_cnt_d = sat_inc(rx_cnt_q, CNT_MAX);
        end else begin
          rx_cnt_d = 16'd0;
        end
        if (!sbrx && (rx_cnt_q == DRX_LAST)) begin
          state_d              = ST_DISC;
          partner_disconnect_d = 1'b1;
        end else begin
          state_d = ST_CONNECTED;
        end
      end
      ST_DISABLED: begin
        state_d = ST_DISC;
      end
      default: begin
        state_d = ST_DISC;
      end
    endcase

    // disable_req outranks disconnect_req; only disable suppresses pulses.
    if (disable_req) begin
      state_d              = ST_DISABLED;
      connect_timeout_d    = 1'b0;
      partner_disconnect_d = 1'b0;
    end else if (disconnect_req) begin
      state_d = ST_DISC;
    end else begin
      state_d = state_d;
    end

    // Any state entry (including a DISC restart) starts all counts afresh.
    if ((state_d != state_q) || disable_req || disconnect_req) begin
      tx_cnt_d = 16'd0;
      rx_cnt_d = 16'd0;
      to_cnt_d = 16'd0;
    end else begin
      tx_cnt_d = tx_cnt_d;
    end
  end

  // State, counter and pulse registers with asynchronous reset.
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      state_q              <= ST_DISC;
      tx_cnt_q             <= 16'd0;
      rx_cnt_q             <= 16'd0;
      to_cnt_q             <= 16'd0;
      connect_timeout_q    <= 1'b0;
      partner_disconnect_q <= 1'b0;
    end else begin
      state_q              <= state_d;
      tx_cnt_q             <= tx_cnt_d;
      rx_cnt_q             <= rx_cnt_d;
      to_cnt_q             <= to_cnt_d;
      connect_timeout_q    <= connect_timeout_d;
      partner_disconnect_q <= partner_disconnect_d;
    end
  end

  // Level outputs decode from registered state so they move with it.
  always_comb begin
    sbtx                = (state_q == ST_CONN_TX) || (state_q == ST_CONNECTED);
    link_connected      = (state_q == ST_CONNECTED);
    tdisconnect_tx_done = (state_q == ST_DISC) && (tx_cnt_q == TX_MAX);
    state               = state_q;
    connect_timeout     = connect_timeout_q;
    partner_disconnect  = partner_disconnect_q;
  end

endmodule

// File: tb/tb_sbtx_link_ctrl.sv
// Scoreboard bench for sbtx_link_ctrl: the driver updates a behavioural
// model and queues the expected post-edge outputs; a monitor pops and
// compares after every clock edge. Directed steps add explicit checks.
module tb_sbtx_link_ctrl;

  localparam int TDTX = 50;
  localparam int CRX  = 25;
  localparam int DRX  = 14;
  localparam int TOUT = 1000;

  logic       sb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       connect_en = 1'b0;
  logic       disconnect_req = 1'b0;
  logic       disable_req = 1'b0;
  logic       sbrx = 1'b0;
  logic       sbtx, link_connected, tdisconnect_tx_done;
  logic       connect_timeout, partner_disconnect;
  logic [1:0] state;

  sbtx_link_ctrl #(
    .TDISCONNECT_TX(TDTX), .TCONNECT_RX(CRX),
    .TDISCONNECT_RX(DRX), .TCONNECT_TIMEOUT(TOUT)
  ) dut (
    .sb_clk(sb_clk), .rst(rst), .connect_en(connect_en),
    .disconnect_req(disconnect_req), .disable_req(disable_req), .sbrx(sbrx),
    .sbtx(sbtx), .link_connected(link_connected),
    .tdisconnect_tx_done(tdisconnect_tx_done), .connect_timeout(connect_timeout),
    .partner_disconnect(partner_disconnect), .state(state)
  );

  always #5 sb_clk = ~sb_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 idle/disconnect, 1 attempting, 2 up, 3 disabled.
  int m_phase   = 0;
  int m_idle    = 0;  // cycles spent in disconnect phase (capped)
  int m_run     = 0;  // current run of qualifying sbrx samples
  int m_attempt = 0;  // cycles spent in the current connect attempt
  logic [6:0] exp_q[$];
  logic [6:0] exp_v, act_v;

  function void model_step(bit r, bit e, bit d, bit x, bit rx);
    int  nxt;
    bit  ct, pd;
    bit  up, line, done;
    ct = 1'b0;
    pd = 1'b0;
    if (r) begin
      m_phase = 0; m_idle = 0; m_run = 0; m_attempt = 0;
      exp_q.push_back(7'd0);
      return;
    end
    nxt = m_phase;
    if (m_phase == 0) begin
      if (m_idle >= TDTX && e) nxt = 1;
      m_idle = (m_idle + 1 > TDTX) ? TDTX : m_idle + 1;
    end else if (m_phase == 1) begin
      m_run = rx ? m_run + 1 : 0;
      m_attempt = m_attempt + 1;
      if (m_run == CRX) nxt = 2;
      else if (m_attempt == TOUT) begin nxt = 0; ct = 1'b1; end
    end else if (m_phase == 2) begin
      m_run = rx ? 0 : m_run + 1;
      if (m_run == DRX) begin nxt = 0; pd = 1'b1; end
    end else begin
      nxt = 0;
    end
    if (x) begin nxt = 3; ct = 1'b0; pd = 1'b0; end
    else if (d) nxt = 0;
    if (x || d || nxt != m_phase) begin
      m_idle = 0; m_run = 0; m_attempt = 0;
    end
    m_phase = nxt;
    up   = (m_phase == 2);
    line = (m_phase == 1) || (m_phase == 2);
    done = (m_phase == 0) && (m_idle == TDTX);
    exp_q.push_back({2'(m_phase), line, up, done, ct, pd});
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, expv);
    end
  endtask

  // Drive n cycles with fixed inputs; returns just after the last edge.
  task automatic cyc(input bit r, input bit e, input bit d, input bit x,
                     input bit rx, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sb_clk);
      rst = r; connect_en = e; disconnect_req = d; disable_req = x; sbrx = rx;
      model_step(r, e, d, x, rx);
      @(posedge sb_clk);
      #2;
    end
  endtask

  // Assert reset away from the edge and check outputs drop immediately.
  task automatic do_reset();
    @(negedge sb_clk);
    rst = 1'b1; disconnect_req = 1'b0; disable_req = 1'b0;
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_now_state", int'(state), 0);
    chk("rst_now_sbtx", int'(sbtx), 0);
    chk("rst_now_link", int'(link_connected), 0);
    chk("rst_now_done", int'(tdisconnect_tx_done), 0);
    chk("rst_now_pulses", int'({connect_timeout, partner_disconnect}), 0);
    @(posedge sb_clk);
    #2;
  endtask

  // Monitor: compare every edge's outputs against the queued expectation.
  initial begin
    forever begin
      @(posedge sb_clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {state, sbtx, link_connected, tdisconnect_tx_done,
                 connect_timeout, partner_disconnect};
        n_checks++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL scoreboard at %0t: got st=%0d sbtx=%0b link=%0b done=%0b to=%0b pd=%0b, want st=%0d sbtx=%0b link=%0b done=%0b to=%0b pd=%0b",
                   $time, act_v[6:5], act_v[4], act_v[3], act_v[2], act_v[1], act_v[0],
                   exp_v[6:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    int  mode, dis_hold, wait_cnt;
    bit  e, d, x, rx;

    cyc(1, 0, 0, 0, 0, 3);
    chk("reset_state", int'(state), 0);
    chk("reset_sbtx", int'(sbtx), 0);

    // Cold start with partner present.
    cyc(0, 1, 0, 0, 1, 50);
    chk("t1_done_after_50", int'(tdisconnect_tx_done), 1);
    chk("t1_sbtx_low_at_50", int'(sbtx), 0);
    cyc(0, 1, 0, 0, 1, 1);
    chk("t1_state_conn_tx", int'(state), 1);
    chk("t1_sbtx_edge_51", int'(sbtx), 1);
    cyc(0, 1, 0, 0, 1, 24);
    chk("t1_not_yet_conn", int'(state), 1);
    cyc(0, 1, 0, 0, 1, 1);
    chk("t1_connected", int'(state), 2);
    chk("t1_link", int'(link_connected), 1);

    // Glitch in qualification restarts the run.
    cyc(0, 1, 1, 0, 1, 1);
    chk("t2_disc_req", int'(state), 0);
    cyc(0, 1, 0, 0, 1, 51);
    chk("t2_conn_tx", int'(state), 1);
    cyc(0, 1, 0, 0, 1, 24);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1, 24);
    chk("t2_run_restarted", int'(state), 1);
    cyc(0, 1, 0, 0, 1, 1);
    chk("t2_connected", int'(state), 2);

    // Timeout with silent partner; connect_en dropping is ignored.
    cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 51);
    chk("t3_conn_tx", int'(state), 1);
    cyc(0, 0, 0, 0, 0, 999);
    chk("t3_before_timeout", int'(state), 1);
    chk("t3_no_early_pulse", int'(connect_timeout), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t3_timeout_pulse", int'(connect_timeout), 1);
    chk("t3_back_to_disc", int'(state), 0);
    chk("t3_sbtx_low", int'(sbtx), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t3_pulse_one_cycle", int'(connect_timeout), 0);
    cyc(0, 0, 0, 0, 0, 48);
    chk("t3_done_not_49", int'(tdisconnect_tx_done), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t3_done_at_50", int'(tdisconnect_tx_done), 1);

    // Partner disconnect: 13 lows tolerated, 14 lows exit.
    cyc(0, 1, 0, 0, 1, 26);
    chk("t4_connected", int'(state), 2);
    cyc(0, 1, 0, 0, 0, 13);
    cyc(0, 1, 0, 0, 1, 1);
    chk("t4_13_low_stays", int'(state), 2);
    cyc(0, 0, 0, 0, 0, 13);
    chk("t4_no_pd_yet", int'(partner_disconnect), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t4_pd_pulse", int'(partner_disconnect), 1);
    chk("t4_disc", int'(state), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t4_pd_one_cycle", int'(partner_disconnect), 0);

    // disable_req coincident with the 14th low sample.
    cyc(0, 1, 0, 0, 1, 80);
    chk("t5_connected", int'(state), 2);
    cyc(0, 1, 0, 0, 0, 13);
    cyc(0, 1, 0, 1, 0, 1);
    chk("t5_disabled", int'(state), 3);
    chk("t5_sbtx_low", int'(sbtx), 0);
    chk("t5_no_pd", int'(partner_disconnect), 0);
    cyc(0, 1, 0, 1, 0, 2);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t5_release_disc", int'(state), 0);
    cyc(0, 0, 0, 0, 0, 49);
    chk("t5_fresh_not_done", int'(tdisconnect_tx_done), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t5_fresh_done", int'(tdisconnect_tx_done), 1);

    // disconnect_req restart at tx_cnt=30, then reset at tx_cnt=40.
    cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 30);
    cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 49);
    chk("t6_not_done_49", int'(tdisconnect_tx_done), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t6_done_50", int'(tdisconnect_tx_done), 1);
    cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 40);
    do_reset();
    cyc(1, 0, 0, 0, 0, 2);
    cyc(0, 1, 0, 0, 1, 80);
    chk("t6_connected_again", int'(state), 2);
    do_reset();
    cyc(1, 0, 0, 0, 0, 2);

    // Randomised segments with biased sbrx and sparse requests.
    dis_hold = 0;
    for (int s = 0; s < 40; s++) begin
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 200; c++) begin
        if (mode == 0) rx = ($urandom_range(0, 63) != 0);
        else if (mode == 1) rx = ($urandom_range(0, 63) == 0);
        else rx = $urandom_range(0, 1);
        e = ($urandom_range(0, 7) != 0);
        d = ($urandom_range(0, 299) == 0);
        if (dis_hold > 0) dis_hold--;
        else if ($urandom_range(0, 499) == 0) dis_hold = $urandom_range(1, 4);
        x = (dis_hold > 0);
        if ($urandom_range(0, 2999) == 0) begin
          do_reset();
        end else begin
          cyc(0, e, d, x, rx, 1);
        end
      end
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge sb_clk);
      wait_cnt++;
    end
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
